// File: rtl/mem_ram_arb_if.sv
// mem_ram_arb_if: bundles the two requester ports and the RAM-side port of
// the data-RAM arbiter.
//   Requester side : req0/1, we0/1, addr0/1[3:0], wdata0/1[31:0] (to arbiter)
//                    gnt0/1, rvalid0/1, rdata0/1[31:0]          (from arbiter)
//   RAM side       : ram_addr[3:0], ram_we, ram_wdata[31:0]    (from arbiter)
//                    ram_rdata[31:0]                            (to arbiter)
// slave  = arbiter view, master = view of the environment driving it.
interface mem_ram_arb_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [3:0]  addr0;
    logic [3:0]  addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        gnt0;
    logic        gnt1;
    logic        rvalid0;
    logic        rvalid1;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic [3:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               ram_addr, ram_we, ram_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/mem_ram_arb.sv
// mem_ram_arb: two-port round-robin arbiter/sequencer for a 16x32 RAM with
// combinational read and write on the rising clock edge. One request is
// latched at a time, driven onto the RAM for exactly one cycle, and read
// data is returned registered one cycle later.
// Ports:
//   clk  - system clock
//   rst  - synchronous, active-high reset
//   bus  - mem_ram_arb_if.slave (requester ports 0/1 and RAM port)
//
// state | meaning
// IDLE  | waiting for a request; latches the winner's transaction
// BUSY  | latched transaction is at the RAM this cycle; gnt[sel] high
module mem_ram_arb (
    input  logic          clk,
    input  logic          rst,
    mem_ram_arb_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        sel_q, sel_d;
    logic        last_q, last_d;
    logic        we_q, we_d;
    logic [3:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        rvalid0_q, rvalid0_d;
    logic        rvalid1_q, rvalid1_d;
    logic        pick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            last_q    <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= 4'h0;
            wdata_q   <= 32'h0;
            rdata0_q  <= 32'h0;
            rdata1_q  <= 32'h0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        pick      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // On a tie the port that was not served last wins.
                    pick    = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    sel_d   = pick;
                    we_d    = pick ? bus.we1    : bus.we0;
                    addr_d  = pick ? bus.addr1  : bus.addr0;
                    wdata_d = pick ? bus.wdata1 : bus.wdata0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                last_d  = sel_q;
                state_d = IDLE;
                if (!we_q) begin
                    if (sel_q) begin
                        rdata1_d  = bus.ram_rdata;
                        rvalid1_d = 1'b1;
                    end else begin
                        rdata0_d  = bus.ram_rdata;
                        rvalid0_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant and write strobe come from registered state only; rst masks them
    // so a reset landing in BUSY never reaches the RAM.
    assign bus.gnt0      = (state_q == BUSY) && !sel_q && !rst;
    assign bus.gnt1      = (state_q == BUSY) &&  sel_q && !rst;
    assign bus.ram_we    = (state_q == BUSY) &&  we_q  && !rst;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.rvalid0   = rvalid0_q;
    assign bus.rvalid1   = rvalid1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
endmodule

// File: tb/tb_mem_ram_arb.sv
module tb_mem_ram_arb;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [31:0] mem [16];

    mem_ram_arb_if bif ();

    mem_ram_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 16x32 RAM: combinational read, write on rising edge.
    assign bif.ram_rdata = mem[bif.ram_addr];
    always @(posedge clk) begin
        if (bif.ram_we) mem[bif.ram_addr] <= bif.ram_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt0"},      {31'h0, bif.gnt0},    32'h0);
        chk({tag, "_gnt1"},      {31'h0, bif.gnt1},    32'h0);
        chk({tag, "_rvalid0"},   {31'h0, bif.rvalid0}, 32'h0);
        chk({tag, "_rvalid1"},   {31'h0, bif.rvalid1}, 32'h0);
        chk({tag, "_ram_we"},    {31'h0, bif.ram_we},  32'h0);
        chk({tag, "_ram_addr"},  {28'h0, bif.ram_addr}, 32'h0);
        chk({tag, "_ram_wdata"}, bif.ram_wdata,        32'h0);
        chk({tag, "_rdata0"},    bif.rdata0,           32'h0);
        chk({tag, "_rdata1"},    bif.rdata1,           32'h0);
    endtask

    initial begin
        int cnt0;
        int cnt1;
        int start0;
        int start1;
        int max_wait;
        int w;

        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
        rst        = 1'b1;
        bif.req0   = 1'b0;
        bif.req1   = 1'b0;
        bif.we0    = 1'b0;
        bif.we1    = 1'b0;
        bif.addr0  = 4'h0;
        bif.addr1  = 4'h0;
        bif.wdata0 = 32'h0;
        bif.wdata1 = 32'h0;

        // Reset state
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Port 0 write addr 3
        bif.req0 = 1'b1; bif.we0 = 1'b1; bif.addr0 = 4'h3; bif.wdata0 = 32'hDEADBEEF;
        tick();
        chk("wr0_gnt0",      {31'h0, bif.gnt0},     32'h1);
        chk("wr0_gnt1",      {31'h0, bif.gnt1},     32'h0);
        chk("wr0_ram_we",    {31'h0, bif.ram_we},   32'h1);
        chk("wr0_ram_addr",  {28'h0, bif.ram_addr}, 32'h3);
        chk("wr0_ram_wdata", bif.ram_wdata,         32'hDEADBEEF);
        bif.req0 = 1'b0;
        tick();
        chk("wr0_we_off",    {31'h0, bif.ram_we},   32'h0);
        chk("wr0_gnt_off",   {31'h0, bif.gnt0},     32'h0);
        chk("wr0_no_rvalid", {31'h0, bif.rvalid0},  32'h0);
        chk("wr0_mem3",      mem[3],                32'hDEADBEEF);
        chk("wr0_addr_hold", {28'h0, bif.ram_addr}, 32'h3);

        // Port 0 read addr 3
        bif.req0 = 1'b1; bif.we0 = 1'b0; bif.addr0 = 4'h3;
        tick();
        chk("rd0_gnt0",      {31'h0, bif.gnt0},     32'h1);
        chk("rd0_ram_we",    {31'h0, bif.ram_we},   32'h0);
        chk("rd0_rvalid_early", {31'h0, bif.rvalid0}, 32'h0);
        bif.req0 = 1'b0;
        tick();
        chk("rd0_rvalid0",   {31'h0, bif.rvalid0},  32'h1);
        chk("rd0_rdata0",    bif.rdata0,            32'hDEADBEEF);
        chk("rd0_rvalid1",   {31'h0, bif.rvalid1},  32'h0);
        tick();
        chk("rd0_rvalid_pulse", {31'h0, bif.rvalid0}, 32'h0);
        chk("rd0_rdata_hold", bif.rdata0,           32'hDEADBEEF);

        // Simultaneous reads of addr 0 after reset: port 0 first
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_rdata0",   bif.rdata0,            32'h0);
        bif.req0 = 1'b1; bif.we0 = 1'b0; bif.addr0 = 4'h0;
        bif.req1 = 1'b1; bif.we1 = 1'b0; bif.addr1 = 4'h0;
        tick();
        chk("tie_gnt0",      {31'h0, bif.gnt0},     32'h1);
        chk("tie_gnt1",      {31'h0, bif.gnt1},     32'h0);
        bif.req0 = 1'b0;
        tick();
        chk("tie_rvalid0",   {31'h0, bif.rvalid0},  32'h1);
        chk("tie_rdata0",    bif.rdata0,            32'h1000_0000);
        chk("tie_gnt1_idle", {31'h0, bif.gnt1},     32'h0);
        tick();
        chk("tie_gnt1_late", {31'h0, bif.gnt1},     32'h1);
        chk("tie_gnt0_late", {31'h0, bif.gnt0},     32'h0);
        bif.req1 = 1'b0;
        tick();
        chk("tie_rvalid1",   {31'h0, bif.rvalid1},  32'h1);
        chk("tie_rdata1",    bif.rdata1,            32'h1000_0000);

        // Continuous contention for 20 cycles
        bif.req0 = 1'b1; bif.we0 = 1'b0; bif.addr0 = 4'h1;
        bif.req1 = 1'b1; bif.we1 = 1'b0; bif.addr1 = 4'h2;
        cnt0 = 0; cnt1 = 0; start0 = 0; start1 = 0; max_wait = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k % 2 == 1) begin
                if (((k - 1) / 2) % 2 == 0) begin
                    chk("alt_gnt0", {30'h0, bif.gnt1, bif.gnt0}, 32'h1);
                end else begin
                    chk("alt_gnt1", {30'h0, bif.gnt1, bif.gnt0}, 32'h2);
                end
            end else begin
                chk("alt_idle", {30'h0, bif.gnt1, bif.gnt0}, 32'h0);
            end
            if (bif.gnt0) begin
                cnt0++;
                w = k - start0 + 1;
                if (w > max_wait) max_wait = w;
                start0 = k + 1;
            end
            if (bif.gnt1) begin
                cnt1++;
                w = k - start1 + 1;
                if (w > max_wait) max_wait = w;
                start1 = k + 1;
            end
            if (k == 20) begin
                bif.req0 = 1'b0;
                bif.req1 = 1'b0;
            end
        end
        chk("cont_cnt0",     cnt0,                  32'd5);
        chk("cont_cnt1",     cnt1,                  32'd5);
        chk("cont_max_wait_le4", {31'h0, max_wait <= 4}, 32'h1);
        chk("cont_rdata0",   bif.rdata0,            32'h1000_0001);
        chk("cont_rdata1",   bif.rdata1,            32'h1000_0002);
        tick();

        // Port 1 writes addr F, port 0 reads it back
        bif.req1 = 1'b1; bif.we1 = 1'b1; bif.addr1 = 4'hF; bif.wdata1 = 32'h12345678;
        tick();
        chk("x_gnt1",        {31'h0, bif.gnt1},     32'h1);
        chk("x_ram_we",      {31'h0, bif.ram_we},   32'h1);
        chk("x_ram_addr",    {28'h0, bif.ram_addr}, 32'hF);
        bif.req1 = 1'b0;
        tick();
        chk("x_no_rvalid1",  {31'h0, bif.rvalid1},  32'h0);
        chk("x_rdata1_keep", bif.rdata1,            32'h1000_0002);
        bif.req0 = 1'b1; bif.we0 = 1'b0; bif.addr0 = 4'hF;
        tick();
        chk("x_gnt0",        {31'h0, bif.gnt0},     32'h1);
        bif.req0 = 1'b0;
        tick();
        chk("x_rvalid0",     {31'h0, bif.rvalid0},  32'h1);
        chk("x_rdata0",      bif.rdata0,            32'h12345678);
        chk("x_rdata1_same", bif.rdata1,            32'h1000_0002);
        tick();

        // Reset asserted while a write is in BUSY
        bif.req0 = 1'b1; bif.we0 = 1'b1; bif.addr0 = 4'h5; bif.wdata0 = 32'hA5A5A5A5;
        tick();
        rst = 1'b1;
        #1;
        chk("rb_ram_we",     {31'h0, bif.ram_we},   32'h0);
        chk("rb_gnt0",       {31'h0, bif.gnt0},     32'h0);
        bif.req0 = 1'b0;
        tick();
        rst = 1'b0;
        chk_reset_outputs("rb_after");
        chk("rb_mem5",       mem[5],                32'h1000_0005);
        tick();
        chk("rb_no_rvalid",  {30'h0, bif.rvalid1, bif.rvalid0}, 32'h0);
        chk("rb_mem5_late",  mem[5],                32'h1000_0005);

        // Load non-zero rdata, then hold idle for 10 cycles
        bif.req1 = 1'b1; bif.we1 = 1'b0; bif.addr1 = 4'hF;
        tick();
        bif.req1 = 1'b0;
        tick();
        chk("pre_rdata1",    bif.rdata1,            32'h12345678);
        bif.req0 = 1'b1; bif.we0 = 1'b0; bif.addr0 = 4'h3;
        tick();
        bif.req0 = 1'b0;
        tick();
        chk("pre_rdata0",    bif.rdata0,            32'hDEADBEEF);
        // Port 0 holds write-looking inputs with req low; they must be ignored.
        bif.we0 = 1'b1; bif.addr0 = 4'h7; bif.wdata0 = 32'hFFFF_0000;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("idle_ram_we", {31'h0, bif.ram_we}, 32'h0);
            chk("idle_flags",  {28'h0, bif.gnt0, bif.gnt1, bif.rvalid0, bif.rvalid1}, 32'h0);
        end
        chk("idle_rdata0",   bif.rdata0,            32'hDEADBEEF);
        chk("idle_rdata1",   bif.rdata1,            32'h12345678);
        chk("idle_mem7",     mem[7],                32'h1000_0007);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
